vga_fb_pixel_pipe: RTL and testbench

//  Sits directly downstream of the VGA timing controller in the pclk domain.

---
 rtl/vga_fb_pixel_pipe.sv | 152 +++++++++++++++
 tb/tb_vga_fb_pixel_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_pixel_pipe.sv
// rtl/vga_fb_pixel_pipe.sv - 640x480 to 320x240 frame-buffer pixel pipeline; VGA_TEST_PATTERN_EN adds colour bars
`timescale 1ns/1ps

module vga_fb_pixel_pipe #(
  parameter int MEM_LAT = 1,
  parameter int FB_W    = 320,
  parameter int FB_H    = 240,
  parameter int ADDR_W  = 17,
  parameter int FCNT_W  = 8
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              valid,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              pattern_sel,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [11:0]       mem_data,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              frame_tick,
  output logic [FCNT_W-1:0] frame_cnt
);

  // Total input-to-connector latency: address register, memory, output register.
  localparam int L = 2 + MEM_LAT;
  localparam logic [ADDR_W:0] FB_PIXELS = (ADDR_W+1)'(FB_W * FB_H);

  logic [L-1:0]        valid_sr_q, valid_sr_d;
  logic [L-1:0]        hs_sr_q, hs_sr_d;
  logic [L-1:0]        vs_sr_q, vs_sr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [11:0]         rgb_q, rgb_d;
  logic                vs_prev_q, vs_prev_d;
  logic                tick_q, tick_d;
  logic [FCNT_W-1:0]   cnt_q, cnt_d;
  logic                frame_edge;

  logic [8:0]          h_half;
  logic [8:0]          v_half;
  logic [ADDR_W-1:0]   addr_calc;
  logic                unused_ok;

  assign h_half = h_cnt[9:1];
  assign v_half = v_cnt[9:1];

  // Pixel doubling: each frame-buffer pixel covers a 2x2 block of screen pixels.
  generate
    if (FB_W == 320) begin : g_addr_shift
      assign addr_calc = (ADDR_W'(v_half) << 8) + (ADDR_W'(v_half) << 6) + ADDR_W'(h_half);
    end else begin : g_addr_generic
      assign addr_calc = ADDR_W'(v_half) * ADDR_W'(FB_W) + ADDR_W'(h_half);
    end
  endgenerate

`ifdef VGA_TEST_PATTERN_EN
  logic [L-2:0][2:0]   bar_sr_q, bar_sr_d;
  logic [L-2:0]        psel_sr_q, psel_sr_d;
  logic [2:0]          bar_idx;

  // h_cnt / 80 without a divider: count how many bar boundaries lie at or left of h.
  assign bar_idx = 3'(h_cnt >= 10'd80)  + 3'(h_cnt >= 10'd160) + 3'(h_cnt >= 10'd240) +
                   3'(h_cnt >= 10'd320) + 3'(h_cnt >= 10'd400) + 3'(h_cnt >= 10'd480) +
                   3'(h_cnt >= 10'd560);

  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 12'hFFF;
      3'd1:    bar_colour = 12'hFF0;
      3'd2:    bar_colour = 12'h0FF;
      3'd3:    bar_colour = 12'h0F0;
      3'd4:    bar_colour = 12'hF0F;
      3'd5:    bar_colour = 12'hF00;
      3'd6:    bar_colour = 12'h00F;
      default: bar_colour = 12'h000;
    endcase
  endfunction

  assign unused_ok = &{1'b0, v_cnt[0], FB_PIXELS[0]};
`else
  assign unused_ok = &{1'b0, h_cnt[0], v_cnt[0], FB_PIXELS[0]};
`endif

  // Next-state: delay lines, address hold when blanking, output mux and frame edge detect.
  always_comb begin
    valid_sr_d = {valid_sr_q[L-2:0], valid};
    hs_sr_d    = {hs_sr_q[L-2:0], hsync};
    vs_sr_d    = {vs_sr_q[L-2:0], vsync};
    mem_addr_d = valid ? addr_calc : mem_addr_q;
    // valid_sr_q[L-2] is the flag that travelled alongside the address now answered by mem_data.
    rgb_d      = valid_sr_q[L-2] ? mem_data : 12'h000;
`ifdef VGA_TEST_PATTERN_EN
    bar_sr_d   = {bar_sr_q[L-3:0], bar_idx};
    psel_sr_d  = {psel_sr_q[L-3:0], pattern_sel};
    if (valid_sr_q[L-2] && psel_sr_q[L-2]) begin
      rgb_d = bar_colour(bar_sr_q[L-2]);
    end
`endif
    frame_edge = vs_prev_q & ~vsync;
    tick_d     = frame_edge;
    cnt_d      = frame_edge ? cnt_q + 1'b1 : cnt_q;
    vs_prev_d  = vsync;
  end

  // State registers; reset loads idle values into every stage so an in-flight line is dropped.
  always_ff @(posedge pclk) begin
    if (reset) begin
      valid_sr_q <= '0;
      hs_sr_q    <= '1;
      vs_sr_q    <= '1;
      mem_addr_q <= '0;
      rgb_q      <= 12'h000;
      vs_prev_q  <= 1'b1;
      tick_q     <= 1'b0;
      cnt_q      <= '0;
`ifdef VGA_TEST_PATTERN_EN
      bar_sr_q   <= '0;
      psel_sr_q  <= '0;
`endif
    end else begin
      valid_sr_q <= valid_sr_d;
      hs_sr_q    <= hs_sr_d;
      vs_sr_q    <= vs_sr_d;
      mem_addr_q <= mem_addr_d;
      rgb_q      <= rgb_d;
      vs_prev_q  <= vs_prev_d;
      tick_q     <= tick_d;
      cnt_q      <= cnt_d;
`ifdef VGA_TEST_PATTERN_EN
      bar_sr_q   <= bar_sr_d;
      psel_sr_q  <= psel_sr_d;
`endif
    end
  end

  assign mem_addr   = mem_addr_q;
  assign vga_r      = rgb_q[11:8];
  assign vga_g      = rgb_q[7:4];
  assign vga_b      = rgb_q[3:0];
  assign hsync_out  = hs_sr_q[L-1];
  assign vsync_out  = vs_sr_q[L-1];
  assign frame_tick = tick_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_vga_fb_pixel_pipe.sv
// tb/tb_vga_fb_pixel_pipe.sv - self-checking bench for vga_fb_pixel_pipe with MEM_LAT=1
`timescale 1ns/1ps

module tb_vga_fb_pixel_pipe;

  localparam int ADDR_W = 17;
  localparam int FCNT_W = 8;

  logic              pclk = 1'b0;
  logic              reset;
  logic              valid;
  logic              hsync;
  logic              vsync;
  logic [9:0]        h_cnt;
  logic [9:0]        v_cnt;
  logic              pattern_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [11:0]       mem_data;
  logic [3:0]        vga_r, vga_g, vga_b;
  logic              hsync_out, vsync_out;
  logic              frame_tick;
  logic [FCNT_W-1:0] frame_cnt;

  always #5 pclk = ~pclk;

  vga_fb_pixel_pipe #(
    .MEM_LAT(1), .FB_W(320), .FB_H(240), .ADDR_W(ADDR_W), .FCNT_W(FCNT_W)
  ) dut (
    .pclk       (pclk),
    .reset      (reset),
    .valid      (valid),
    .hsync      (hsync),
    .vsync      (vsync),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .frame_tick (frame_tick),
    .frame_cnt  (frame_cnt)
  );

  // Behavioural synchronous RAM, one cycle of read latency.
  logic [11:0] ram [0:76799];
  logic        force_fff;
  always @(posedge pclk) mem_data <= force_fff ? 12'hFFF : ram[mem_addr];

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        v;
    logic [9:0]  h;
    logic [9:0]  vc;
    logic [16:0] addr;
  } vec_t;
  vec_t vecs[$];

  logic [11:0] bars [8];

  int errors = 0;
  int checks = 0;
  logic [16:0] addr_m;
  logic        vs_prev_m;
  logic [7:0]  cnt_m;
  int          ticks_seen, hs_low, vs_low;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle; expected outputs are queued now and popped three edges later.
  task automatic step(input logic v, input logic [9:0] h, input logic [9:0] vc,
                      input logic hs, input logic vs, input logic ps);
    exp_t e;
    logic exp_tick;
    valid = v; h_cnt = h; v_cnt = vc; hsync = hs; vsync = vs; pattern_sel = ps;
    if (v) addr_m = 17'((int'(vc) / 2) * 320 + int'(h) / 2);
    e.hs = hs;
    e.vs = vs;
    e.rgb = v ? ram[addr_m] : 12'h000;
`ifdef VGA_TEST_PATTERN_EN
    if (v && ps) e.rgb = bars[int'(h) / 80];
`endif
    exp_tick = vs_prev_m & ~vs;
    if (exp_tick) cnt_m = cnt_m + 8'd1;
    vs_prev_m = vs;
    exp_q.push_back(e);
    @(posedge pclk);
    #1;
    e = exp_q.pop_front();
    check("rgb", {20'd0, vga_r, vga_g, vga_b}, {20'd0, e.rgb});
    check("hsync_out", {31'd0, hsync_out}, {31'd0, e.hs});
    check("vsync_out", {31'd0, vsync_out}, {31'd0, e.vs});
    check("mem_addr", {15'd0, mem_addr}, {15'd0, addr_m});
    check("frame_tick", {31'd0, frame_tick}, {31'd0, exp_tick});
    check("frame_cnt", {24'd0, frame_cnt}, {24'd0, cnt_m});
    if (frame_tick) ticks_seen++;
    if (!hsync_out) hs_low++;
    if (!vsync_out) vs_low++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    reset = 1'b1;
    valid = 1'b0; h_cnt = '0; v_cnt = '0; hsync = 1'b1; vsync = 1'b1; pattern_sel = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge pclk);
      #1;
      check("rst_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'h0);
      check("rst_hsync", {31'd0, hsync_out}, 32'd1);
      check("rst_vsync", {31'd0, vsync_out}, 32'd1);
      check("rst_addr", {15'd0, mem_addr}, 32'd0);
      check("rst_tick", {31'd0, frame_tick}, 32'd0);
      check("rst_cnt", {24'd0, frame_cnt}, 32'd0);
    end
    reset = 1'b0;
    exp_q.delete();
    e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1;
    exp_q.push_back(e);
    exp_q.push_back(e);
    addr_m = '0;
    vs_prev_m = 1'b1;
    cnt_m = '0;
  endtask

  initial begin
    bars[0] = 12'hFFF; bars[1] = 12'hFF0; bars[2] = 12'h0FF; bars[3] = 12'h0F0;
    bars[4] = 12'hF0F; bars[5] = 12'hF00; bars[6] = 12'h00F; bars[7] = 12'h000;
    for (int i = 0; i < 76800; i++) ram[i] = 12'(i * 7 + 3);
    ram[322] = 12'hABC;
    force_fff = 1'b0;
    ticks_seen = 0; hs_low = 0; vs_low = 0;

    vecs.push_back('{1'b1, 10'd5,   10'd3,   17'd322});
    vecs.push_back('{1'b1, 10'd639, 10'd479, 17'd76799});
    vecs.push_back('{1'b1, 10'd0,   10'd0,   17'd0});
    vecs.push_back('{1'b1, 10'd1,   10'd1,   17'd0});
    vecs.push_back('{1'b1, 10'd2,   10'd0,   17'd1});
    vecs.push_back('{1'b1, 10'd0,   10'd2,   17'd320});
    vecs.push_back('{1'b0, 10'd0,   10'd0,   17'd320});
    vecs.push_back('{1'b1, 10'd320, 10'd240, 17'd38560});
    vecs.push_back('{1'b1, 10'd638, 10'd478, 17'd76799});
    vecs.push_back('{1'b1, 10'd7,   10'd5,   17'd643});

    // Reset state, then three quiet cycles with no tick.
    do_reset(3);
    idle(3);

    // Address vectors incl. boundaries and pixel doubling.
    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].h, vecs[i].vc, 1'b1, 1'b1, 1'b0);
      check("vec_addr", {15'd0, mem_addr}, {15'd0, vecs[i].addr});
    end
    idle(3);

    // Pixel at (5,3) reads 12'hABC and appears three cycles later.
    step(1'b1, 10'd5, 10'd3, 1'b1, 1'b1, 1'b0);
    idle(2);
    check("abc_r", {28'd0, vga_r}, 32'hA);
    check("abc_g", {28'd0, vga_g}, 32'hB);
    check("abc_b", {28'd0, vga_b}, 32'hC);
    idle(2);

    // Blanking forces black even with the RAM returning all ones; address holds.
    step(1'b1, 10'd10, 10'd10, 1'b1, 1'b1, 1'b0);
    step(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
    force_fff = 1'b1;
    idle(4);
    check("hold_addr", {15'd0, mem_addr}, 32'd1605);
    force_fff = 1'b0;
    idle(3);

    // Four 800-cycle lines: 96-cycle hsync pulses, vsync low for lines 1 and 2.
    hs_low = 0; vs_low = 0;
    for (int ln = 0; ln < 4; ln++) begin
      for (int c = 0; c < 800; c++) begin
        logic act;
        act = (ln == 0 || ln == 3) && c < 640;
        step(act, act ? 10'(c) : 10'd0, act ? 10'(ln) : 10'd0,
             !(c >= 656 && c < 752), !(ln == 1 || ln == 2), 1'b0);
      end
    end
    idle(3);
    check("hsync_width", hs_low, 384);
    check("vsync_width", vs_low, 1600);

    // Reset in the middle of active video.
    for (int i = 0; i < 4; i++) step(1'b1, 10'(100 + i), 10'd20, 1'b1, 1'b1, 1'b0);
    do_reset(2);
    idle(2);

    // 257 vsync falling edges wrap the frame counter to 1.
    ticks_seen = 0;
    for (int f = 0; f < 257; f++) begin
      step(1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
    end
    idle(3);
    check("tick_count", ticks_seen, 257);
    check("frame_cnt_wrap", {24'd0, frame_cnt}, 32'd1);

`ifdef VGA_TEST_PATTERN_EN
    step(1'b1, 10'd100, 10'd0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 10'd600, 10'd0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
    check("bar_h100", {20'd0, vga_r, vga_g, vga_b}, 32'hFF0);
    step(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
    check("bar_h600", {20'd0, vga_r, vga_g, vga_b}, 32'h000);
    idle(3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
